// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: turns one 256-bit cache line request into a 4-beat 64-bit memory burst
module cacheline_burst_adapter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int BEATS   = 4,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] line_address,
    input  logic              line_read,
    input  logic              line_write,
    input  logic [LINE_W-1:0] line_wdata,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_resp,
    output logic [ADDR_W-1:0] burst_address,
    output logic              burst_read,
    output logic              burst_write,
    output logic [BURST_W-1:0] burst_wdata,
    input  logic [BURST_W-1:0] burst_rdata,
    input  logic              burst_resp
);
    localparam int BW  = $clog2(BEATS);
    localparam int OFF = $clog2(LINE_W / 8);
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;
    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d, rline_q, rline_d;
    logic              last;
    assign last = beat_q == BW'(BEATS - 1);
    // next state, beat slot bookkeeping and request latching; read wins when both are requested
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            IDLE: begin
                if (line_read || line_write)
                    addr_d = {line_address[ADDR_W-1:OFF], {OFF{1'b0}}};
                if (line_read)
                    state_d = RD_BURST;
                else if (line_write) begin
                    state_d = WR_BURST;
                    wline_d = line_wdata;
                end
            end
            RD_BURST: begin
                if (burst_resp) begin
                    rline_d[beat_q*BURST_W +: BURST_W] = burst_rdata;
                    beat_d  = beat_q + 1'b1;
                    state_d = last ? RESP : RD_BURST;
                end
            end
            WR_BURST: begin
                if (burst_resp) begin
                    beat_d  = beat_q + 1'b1;
                    state_d = last ? RESP : WR_BURST;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end
    // state registers; reset abandons any burst in progress and clears every output
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end
    assign line_resp     = state_q == RESP;
    assign burst_read    = state_q == RD_BURST;
    assign burst_write   = state_q == WR_BURST;
    assign burst_address = addr_q;
    assign line_rdata    = rline_q;
    assign burst_wdata   = wline_q[beat_q*BURST_W +: BURST_W];
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb_cacheline_burst_adapter: directed vector bench for the line-to-burst adapter
module tb_cacheline_burst_adapter;
    logic         clk = 0;
    logic         rst;
    logic [31:0]  line_address;
    logic         line_read, line_write;
    logic [255:0] line_wdata, line_rdata;
    logic         line_resp;
    logic [31:0]  burst_address;
    logic         burst_read, burst_write;
    logic [63:0]  burst_wdata, burst_rdata;
    logic         burst_resp;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0]       addr;
        logic [3:0][63:0]  b;
        logic [31:0]       exp_addr;
        logic [255:0]      exp_line;
    } rd_vec_t;
    rd_vec_t vecs [3];

    cacheline_burst_adapter dut (
        .clk(clk), .rst(rst), .line_address(line_address), .line_read(line_read),
        .line_write(line_write), .line_wdata(line_wdata), .line_rdata(line_rdata),
        .line_resp(line_resp), .burst_address(burst_address), .burst_read(burst_read),
        .burst_write(burst_write), .burst_wdata(burst_wdata), .burst_rdata(burst_rdata),
        .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_zero();
        chk("rst_line_resp", 256'(line_resp), 256'd0);
        chk("rst_burst_read", 256'(burst_read), 256'd0);
        chk("rst_burst_write", 256'(burst_write), 256'd0);
        chk("rst_burst_addr", 256'(burst_address), 256'd0);
        chk("rst_burst_wdata", 256'(burst_wdata), 256'd0);
        chk("rst_line_rdata", line_rdata, 256'd0);
    endtask

    task automatic do_read(input int i, input bit both, input bit hold);
        @(negedge clk);
        line_read = 1;
        line_write = both;
        line_wdata = {4{64'hBADBADBADBADBAD0}};
        line_address = vecs[i].addr;
        @(negedge clk);
        chk("rd_start", 256'(burst_read), 256'd1);
        chk("rd_addr", 256'(burst_address), 256'(vecs[i].exp_addr));
        for (int k = 0; k < 4; k++) begin
            if (both) chk("both_no_write", 256'(burst_write), 256'd0);
            chk("rd_no_resp", 256'(line_resp), 256'd0);
            burst_resp = 1;
            burst_rdata = vecs[i].b[k];
            @(negedge clk);
            chk("rd_addr_hold", 256'(burst_address), 256'(vecs[i].exp_addr));
            if (k < 3) chk("rd_active", 256'(burst_read), 256'd1);
        end
        chk("rd_resp", 256'(line_resp), 256'd1);
        chk("rd_dropped", 256'(burst_read), 256'd0);
        chk("rd_line", line_rdata, vecs[i].exp_line);
        line_read = 0;
        line_write = 0;
        burst_resp = hold;
        burst_rdata = 64'hBAD0BAD0BAD0BAD0;
        @(negedge clk);
        burst_resp = 0;
        chk("rd_resp_pulse", 256'(line_resp), 256'd0);
        chk("rd_idle", 256'(burst_read), 256'd0);
        chk("rd_line_keep", line_rdata, vecs[i].exp_line);
    endtask

    task automatic do_write(input int waits, input logic [255:0] prev_rline);
        logic [3:0][63:0] lw;
        lw = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
        @(negedge clk);
        line_write = 1;
        line_wdata = lw;
        line_address = 32'h0000_201C;
        @(negedge clk);
        line_wdata = '1;
        chk("wr_addr", 256'(burst_address), 256'h2000);
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < waits; w++) begin
                chk("wr_wait_active", 256'(burst_write), 256'd1);
                chk("wr_wait_data", 256'(burst_wdata), 256'(lw[k]));
                chk("wr_no_resp", 256'(line_resp), 256'd0);
                @(negedge clk);
            end
            chk("wr_active", 256'(burst_write), 256'd1);
            chk("wr_data", 256'(burst_wdata), 256'(lw[k]));
            burst_resp = 1;
            @(negedge clk);
            burst_resp = 0;
        end
        chk("wr_resp", 256'(line_resp), 256'd1);
        chk("wr_dropped", 256'(burst_write), 256'd0);
        line_write = 0;
        @(negedge clk);
        chk("wr_resp_pulse", 256'(line_resp), 256'd0);
        chk("wr_rline_keep", line_rdata, prev_rline);
    endtask

    initial begin
        vecs[0].addr = 32'h0000_1040;
        vecs[0].b = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        vecs[0].exp_addr = 32'h0000_1040;
        vecs[0].exp_line = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
        vecs[1].addr = 32'h1234_567F;
        vecs[1].b = {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
        vecs[1].exp_addr = 32'h1234_5660;
        vecs[1].exp_line = 256'hFFFFFFFFFFFFFFFF_0000000000000000_FEDCBA9876543210_0123456789ABCDEF;
        vecs[2].addr = 32'hFFFF_FFFF;
        vecs[2].b = {64'h0000000100000002, 64'hDEADBEEFCAFEF00D, 64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5};
        vecs[2].exp_addr = 32'hFFFF_FFE0;
        vecs[2].exp_line = 256'h0000000100000002_DEADBEEFCAFEF00D_5A5A5A5A5A5A5A5A_A5A5A5A5A5A5A5A5;

        rst = 0;
        line_address = '0;
        line_read = 0;
        line_write = 0;
        line_wdata = '0;
        burst_rdata = '0;
        burst_resp = 0;
        repeat (2) @(negedge clk);
        chk_idle_zero();
        rst = 1;

        for (int i = 0; i < 3; i++) do_read(i, 0, 0);
        do_write(2, vecs[2].exp_line);
        do_read(0, 1, 0);

        burst_resp = 1;
        burst_rdata = 64'hBAD1BAD1BAD1BAD1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_resp_no_read", 256'(burst_read), 256'd0);
            chk("idle_resp_no_write", 256'(burst_write), 256'd0);
            chk("idle_resp_no_lresp", 256'(line_resp), 256'd0);
            chk("idle_resp_rline", line_rdata, vecs[0].exp_line);
        end
        burst_resp = 0;
        do_read(1, 0, 1);

        @(negedge clk);
        line_read = 1;
        line_address = vecs[2].addr;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            burst_resp = 1;
            burst_rdata = vecs[2].b[k];
            @(negedge clk);
        end
        burst_resp = 0;
        line_read = 0;
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk_idle_zero();
        @(negedge clk);
        chk("abort_no_resp", 256'(line_resp), 256'd0);
        chk("abort_stays_idle", 256'(burst_read), 256'd0);
        do_read(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
